// File: rtl/p66b_rx_blocklock_pkg.sv
// Shared constants and types for the 64b/66b RX block-lock path.
package p66b_rx_blocklock_pkg;

    // Raw word width, payload width and descrambler length.
    localparam int unsigned DW = 66;
    localparam int unsigned PW = DW - 2;
    localparam int unsigned PB = 58;

    // Feedback taps of x^58 + x^39 + 1, indexed into the shift register.
    localparam int unsigned POLY_TAP_A = 38;
    localparam int unsigned POLY_TAP_B = 57;

    // The two legal sync headers.
    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_SLIP   = 2'd1,
        S_LOCKED = 2'd2
    } blk_state_e;

    // A header is good only if its two bits differ.
    function automatic logic sh_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/p64b_descramble_step.sv
// Combinational one-word step of the self-synchronising x^58+x^39+1
// descrambler: {state, scrambled payload} -> {next state, clear payload}.
module p64b_descramble_step
    import p66b_rx_blocklock_pkg::*;
(
    input  logic [PB-1:0] state,
    input  logic [PW-1:0] payload,
    output logic [PB-1:0] next_state,
    output logic [PW-1:0] clear
);

    logic [PB-1:0] shift;

    // Walk the payload bit 0 first; the register shifts in received (scrambled) bits.
    always_comb begin
        shift = state;
        clear = '0;
        for (int k = 0; k < int'(PW); k++) begin
            clear[k] = payload[k] ^ shift[POLY_TAP_A] ^ shift[POLY_TAP_B];
            shift    = {shift[PB-2:0], payload[k]};
        end
        next_state = shift;
    end

endmodule

// File: rtl/p66b_rx_blocklock.sv
// 64b/66b receive block aligner: hunts for sync-header lock, requests gearbox
// bit slips, and descrambles the payload of every valid word.
module p66b_rx_blocklock
    import p66b_rx_blocklock_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 64,
    parameter int unsigned BAD_LIMIT  = 16,
    parameter int unsigned SLIP_WAIT  = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_slip,
    output logic          o_lock,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    localparam int unsigned SH_W   = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BAD_W  = $clog2(BAD_LIMIT + 1);
    localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(LOCK_COUNT);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT);

    blk_state_e        state;
    logic [SH_W-1:0]   sh_cnt;
    logic [BAD_W-1:0]  bad_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic [SH_W-1:0]   sh_inc;
    logic [BAD_W-1:0]  bad_inc;
    logic [WAIT_W-1:0] wait_inc;

    logic              hdr_good;
    logic              window_end;
    logic              bad_hit;
    logic              lock_next;

    logic [PB-1:0]     descr_state;
    logic [PB-1:0]     descr_next;
    logic [PW-1:0]     clear_payload;

    assign hdr_good   = sh_valid(i_data[1:0]);
    assign sh_inc     = sh_cnt + SH_W'(1);
    assign bad_inc    = bad_cnt + BAD_W'(1);
    assign wait_inc   = wait_cnt + WAIT_W'(1);
    assign window_end = (sh_inc == SH_LAST);
    assign bad_hit    = !hdr_good && (bad_inc == BAD_LAST);

    p64b_descramble_step u_descramble (
        .state      (descr_state),
        .payload    (i_data[DW-1:2]),
        .next_state (descr_next),
        .clear      (clear_payload)
    );

    // Lock value after this cycle; o_valid needs it in the same cycle as the word.
    always_comb begin
        lock_next = o_lock;
        if (i_valid) begin
            case (state)
                S_HUNT:   if (hdr_good && window_end && (bad_cnt == '0)) lock_next = 1'b1;
                S_LOCKED: if (bad_hit) lock_next = 1'b0;
                default:  lock_next = o_lock;
            endcase
        end
    end

    // Lock FSM with window counters; only valid words move it, unlock beats window end.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= S_HUNT;
            sh_cnt   <= '0;
            bad_cnt  <= '0;
            wait_cnt <= '0;
            o_slip   <= 1'b0;
            o_lock   <= 1'b0;
            o_valid  <= 1'b0;
        end else begin
            o_slip  <= 1'b0;
            o_lock  <= lock_next;
            o_valid <= i_valid & lock_next;
            if (i_valid) begin
                unique case (state)
                    S_HUNT: begin
                        if (!hdr_good) begin
                            state    <= S_SLIP;
                            o_slip   <= 1'b1;
                            sh_cnt   <= '0;
                            bad_cnt  <= '0;
                            wait_cnt <= '0;
                        end else if (window_end) begin
                            sh_cnt  <= '0;
                            bad_cnt <= '0;
                            if (bad_cnt == '0) state <= S_LOCKED;
                        end else begin
                            sh_cnt <= sh_inc;
                        end
                    end
                    S_LOCKED: begin
                        if (bad_hit) begin
                            state    <= S_SLIP;
                            o_slip   <= 1'b1;
                            sh_cnt   <= '0;
                            bad_cnt  <= '0;
                            wait_cnt <= '0;
                        end else if (window_end) begin
                            sh_cnt  <= '0;
                            bad_cnt <= '0;
                        end else begin
                            sh_cnt <= sh_inc;
                            if (!hdr_good) bad_cnt <= bad_inc;
                        end
                    end
                    S_SLIP: begin
                        // Words here are mid-realignment in the gearbox; headers are not judged.
                        if (wait_inc == WAIT_LAST) begin
                            state    <= S_HUNT;
                            wait_cnt <= '0;
                            sh_cnt   <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            wait_cnt <= wait_inc;
                        end
                    end
                    default: state <= S_HUNT;
                endcase
            end
        end
    end

    // Descrambler runs on every valid word, locked or not, so it is in sync at lock.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            descr_state <= '0;
            o_data      <= '0;
        end else if (i_valid) begin
            descr_state <= descr_next;
            o_data      <= {clear_payload, i_data[1:0]};
        end
    end

endmodule

// File: tb/tb_p66b_rx_blocklock.sv
// Scoreboard bench: a TX block stream with a bit-slipping gearbox model feeds
// the DUT; expected status/data are queued per cycle and checked by a monitor.
module tb_p66b_rx_blocklock;

    localparam int LOCK_COUNT = 64;
    localparam int BAD_LIMIT  = 16;
    localparam int SLIP_WAIT  = 4;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        vld  = 1'b0;
    logic [65:0] din  = '0;
    logic        slip;
    logic        lock;
    logic        ovld;
    logic [65:0] dout;

    always #5 clk = ~clk;

    p66b_rx_blocklock dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_valid (vld),
        .i_data  (din),
        .o_slip  (slip),
        .o_lock  (lock),
        .o_valid (ovld),
        .o_data  (dout)
    );

    typedef struct packed {
        logic        lock;
        logic        slip;
        logic        valid;
        logic        chk;
        logic [65:0] data;
    } exp_t;

    exp_t        st_q[$];
    logic [65:0] data_q[$];
    logic [65:0] blk[$];
    logic [63:0] pl[$];
    logic [57:0] tx_s;

    int n_checks  = 0;
    int n_fail    = 0;
    int slip_seen = 0;
    int pos       = 0;

    // Reference model: 0 hunting, 1 waiting after slip, 2 locked.
    int          m_mode, m_win, m_bad, m_wait;
    bit          m_lock;
    int          last_pos;
    bit          hold_known;
    logic [65:0] hold_data;

    task automatic check1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check66(input string nm, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // TX side: scramble each payload with the x^58+x^39+1 scrambler, header in clear.
    task automatic gen_stream(input int n, input bit zero, input logic [57:0] seed);
        logic [63:0] d;
        logic [63:0] sc;
        logic [1:0]  h;
        logic        b;
        tx_s = seed;
        blk.delete();
        pl.delete();
        for (int k = 0; k < n; k++) begin
            d = zero ? 64'h0 : {$urandom(), $urandom()};
            h = (zero || $urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            for (int i = 0; i < 64; i++) begin
                b     = d[i] ^ tx_s[38] ^ tx_s[57];
                sc[i] = b;
                tx_s  = {tx_s[56:0], b};
            end
            pl.push_back(d);
            blk.push_back({sc, h});
        end
    endtask

    // Corrupt n distinct headers among blocks lo..hi.
    task automatic mark_bads(input int lo, input int hi, input int n);
        int          done = 0;
        int          k;
        logic [65:0] t;
        for (int tries = 0; tries < 10000 && done < n; tries++) begin
            k = $urandom_range(hi, lo);
            t = blk[k];
            if (t[1:0] == 2'b01 || t[1:0] == 2'b10) begin
                t[1:0] = $urandom_range(0, 1) ? 2'b11 : 2'b00;
                blk[k] = t;
                done++;
            end
        end
    endtask

    // Gearbox view: 66 consecutive stream bits starting at bit position p.
    function automatic logic [65:0] rx_word(input int p);
        logic [65:0] w;
        logic [65:0] t;
        w = '0;
        for (int i = 0; i < 66; i++) begin
            t    = blk[(p + i) / 66];
            w[i] = t[(p + i) % 66];
        end
        return w;
    endfunction

    task automatic model_reset();
        m_mode     = 0;
        m_win      = 0;
        m_bad      = 0;
        m_wait     = 0;
        m_lock     = 1'b0;
        last_pos   = -1000;
        hold_known = 1'b1;
        hold_data  = '0;
    endtask

    // One valid word through the lock rules; sl reports a slip request.
    task automatic model_word(input logic [1:0] h, output bit sl);
        bit good;
        good = (h == 2'b01) || (h == 2'b10);
        sl   = 1'b0;
        if (m_mode == 1) begin
            m_wait++;
            if (m_wait == SLIP_WAIT) begin
                m_mode = 0;
                m_win  = 0;
                m_bad  = 0;
            end
        end else if (m_mode == 0 && !good) begin
            sl     = 1'b1;
            m_mode = 1;
            m_wait = 0;
            m_win  = 0;
            m_bad  = 0;
        end else begin
            m_win = m_win + 1;
            m_bad = m_bad + (good ? 0 : 1);
            if (m_mode == 2 && m_bad == BAD_LIMIT) begin
                sl     = 1'b1;
                m_lock = 1'b0;
                m_mode = 1;
                m_wait = 0;
                m_win  = 0;
                m_bad  = 0;
            end else if (m_win == LOCK_COUNT) begin
                if (m_mode == 0 && m_bad == 0) begin
                    m_mode = 2;
                    m_lock = 1'b1;
                end
                m_win = 0;
                m_bad = 0;
            end
        end
    endtask

    // One cycle of stimulus plus its expected response.
    task automatic drive(input bit v, input bit r);
        exp_t        e;
        bit          sl;
        bit          synced;
        logic [65:0] w;
        logic [95:0] junk;
        @(negedge clk);
        if (slip === 1'b1) pos = pos - 1;
        w    = rx_word(pos);
        junk = {$urandom(), $urandom(), $urandom()};
        rst  = r;
        vld  = v;
        din  = v ? w : junk[65:0];
        e    = '0;
        if (r) begin
            model_reset();
            e.chk  = 1'b1;
            e.data = '0;
            if (v) pos = pos + 66;
        end else if (v) begin
            model_word(w[1:0], sl);
            e.slip  = sl;
            e.lock  = m_lock;
            e.valid = m_lock;
            synced  = (pos % 66 == 0) && (last_pos == pos - 66);
            if (synced) begin
                e.chk      = 1'b1;
                e.data     = {pl[pos / 66], w[1:0]};
                hold_known = 1'b1;
                hold_data  = e.data;
            end else begin
                hold_known = 1'b0;
            end
            if (e.valid && synced) data_q.push_back(e.data);
            last_pos = pos;
            pos      = pos + 66;
        end else begin
            e.lock = m_lock;
            e.chk  = hold_known;
            e.data = hold_data;
        end
        st_q.push_back(e);
    endtask

    // vmode: 0 always valid, 1 alternate valid/idle, 2 random 3-in-4 valid.
    task automatic run(input int n, input int vmode);
        bit v;
        for (int i = 0; i < n; i++) begin
            if (vmode == 0)      v = 1'b1;
            else if (vmode == 1) v = (i % 2 == 0);
            else                 v = ($urandom_range(0, 3) != 0);
            drive(v, 1'b0);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: per-cycle status plus data scoreboard popped on o_valid.
    initial begin
        exp_t        e;
        logic [65:0] d;
        forever begin
            @(posedge clk);
            #1;
            if (slip === 1'b1) slip_seen++;
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                check1("o_lock", lock, e.lock);
                check1("o_slip", slip, e.slip);
                check1("o_valid", ovld, e.valid);
                if (e.chk) check66("o_data", dout, e.data);
            end
            if (ovld === 1'b1) begin
                if (data_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_word: o_valid=1 with none expected, o_data=%h", dout);
                end else begin
                    d = data_q.pop_front();
                    check66("out_word", dout, d);
                end
            end
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        // 1: aligned, zero payload.
        gen_stream(120, 1'b1, '0);
        pos = 0;
        slip_seen = 0;
        drive(1'b0, 1'b1);
        run(80, 0);
        settle();
        check_int("s1_slips", slip_seen, 0);
        check1("s1_lock", lock, 1'b1);

        // 2: stream 3 bits off.
        gen_stream(120, 1'b1, '0);
        pos = 3;
        drive(1'b0, 1'b1);
        slip_seen = 0;
        run(100, 0);
        settle();
        check_int("s2_slips", slip_seen, 3);
        check1("s2_lock", lock, 1'b1);

        // 3: 15 bad headers in one window hold lock, 16 in the next drop it.
        gen_stream(230, 1'b0, 58'h1F0_0DD1_2345_6789);
        mark_bads(64, 127, 15);
        mark_bads(128, 191, 16);
        pos = 0;
        drive(1'b0, 1'b1);
        slip_seen = 0;
        run(128, 0);
        settle();
        check1("s3_hold15", lock, 1'b1);
        check_int("s3_slips15", slip_seen, 0);
        run(80, 0);
        settle();
        check1("s3_drop16", lock, 1'b0);
        check1("s3_slipped", slip_seen > 0, 1'b1);

        // 4: scrambled random payload from a nonzero TX state.
        gen_stream(100, 1'b0, 58'h2AB_CDEF_0123_4567);
        pos = 0;
        drive(1'b0, 1'b1);
        run(90, 0);
        settle();
        check1("s4_lock", lock, 1'b1);

        // 5: valid every other cycle.
        gen_stream(100, 1'b1, '0);
        pos = 0;
        drive(1'b0, 1'b1);
        run(126, 1);
        settle();
        check1("s5_nolock63", lock, 1'b0);
        run(2, 1);
        settle();
        check1("s5_lock64", lock, 1'b1);

        // 6: reset while locked, then a full relock window.
        gen_stream(200, 1'b0, 58'h0F0_F0F0_A5A5_5A5A);
        pos = 0;
        drive(1'b0, 1'b1);
        run(74, 0);
        settle();
        check1("s6_locked", lock, 1'b1);
        drive(1'b1, 1'b1);
        settle();
        check1("s6_rst_lock", lock, 1'b0);
        check1("s6_rst_valid", ovld, 1'b0);
        check66("s6_rst_data", dout, '0);
        run(63, 0);
        settle();
        check1("s6_nolock63", lock, 1'b0);
        run(1, 0);
        settle();
        check1("s6_relock", lock, 1'b1);

        // 7: random offset and random valid pattern.
        gen_stream(160, 1'b0, {$urandom(), $urandom()});
        pos = $urandom_range(5, 0);
        drive(1'b0, 1'b1);
        run(140, 2);

        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        settle();
        check_int("words_left", data_q.size(), 0);
        check_int("status_left", st_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
